npc_bpred: RTL and testbench

- Parametrised successor of the next-PC unit. Owns the fetch PC register and predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves branches/jumps arriving from EX, raises the pipeline flush (pcclear) and redirect on misprediction, and updates the BTB.
- Keeps saturating branch statistics counters. Sits between IF and EX of the redirect pipeline.

---
 rtl/npc_bpred_pkg.sv | 16 +
 rtl/npc_bpred_if.sv | 37 +++
 rtl/npc_bpred_sat_counter.sv | 22 ++
 rtl/npc_bpred.sv | 107 ++++++++++
 tb/tb_npc_bpred.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/npc_bpred_pkg.sv
// Shared encodings for the next-PC / branch predictor unit.
package npc_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_COND = 2'd1,
    KIND_JUMP = 2'd2,
    KIND_JR   = 2'd3
  } res_kind_e;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

endpackage

// File: rtl/npc_bpred_if.sv
// Fetch, resolution and statistics signals between the pipeline and npc_bpred.
// Handshake: res_valid qualifies the res_* fields for one cycle; there is no ready,
// the unit consumes a resolution only in a cycle where pcen = 1.
interface npc_bpred_if #(
  parameter int AW = 32,
  parameter int CW = 16
);
  logic          pcen;
  logic [AW-1:0] pc;
  logic          pred_taken;
  logic [AW-1:0] pred_npc;
  logic          res_valid;
  logic [1:0]    res_kind;
  logic [AW-1:0] res_pc;
  logic          res_taken;
  logic [AW-1:0] res_target;
  logic [AW-1:0] res_pred_npc;
  logic          pcclear;
  logic [AW-1:0] redirect_pc;
  logic          stat_clr;
  logic [CW-1:0] uncondsum;
  logic [CW-1:0] condsum;
  logic [CW-1:0] condsuccsum;
  logic [CW-1:0] mispredsum;

  modport master (
    output pcen, res_valid, res_kind, res_pc, res_taken, res_target, res_pred_npc, stat_clr,
    input  pc, pred_taken, pred_npc, pcclear, redirect_pc,
           uncondsum, condsum, condsuccsum, mispredsum
  );

  modport slave (
    input  pcen, res_valid, res_kind, res_pc, res_taken, res_target, res_pred_npc, stat_clr,
    output pc, pred_taken, pred_npc, pcclear, redirect_pc,
           uncondsum, condsum, condsuccsum, mispredsum
  );
endinterface

// File: rtl/npc_bpred_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/npc_bpred.sv
// Fetch PC register with a direct-mapped BTB predictor, EX-side resolution/redirect
// and saturating branch statistics.
module npc_bpred
  import npc_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          ENTRIES  = 16,
  parameter int          CW       = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic        clk,
  input logic        rst_n,
  npc_bpred_if.slave bus
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = AW - IW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [AW-1:0]      target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [AW-1:0]      pc_q;

  logic [IW-1:0] look_idx, res_idx;
  logic          look_hit, res_hit, act_taken, upd;
  logic [AW-1:0] act_npc;
  logic [1:0]    res_ctr;

  // Lookup for the current fetch PC
  assign look_idx       = pc_q[IW+1:2];
  assign look_hit       = valid_q[look_idx] && (tag_q[look_idx] == pc_q[AW-1:IW+2]);
  assign bus.pc         = pc_q;
  assign bus.pred_taken = look_hit && ctr_q[look_idx][1];
  assign bus.pred_npc   = bus.pred_taken ? target_q[look_idx] : pc_q + AW'(4);

  // Resolution of the instruction sitting in EX
  assign res_idx   = bus.res_pc[IW+1:2];
  assign res_hit   = valid_q[res_idx] && (tag_q[res_idx] == bus.res_pc[AW-1:IW+2]);
  assign res_ctr   = ctr_q[res_idx];
  assign act_taken = bus.res_kind[1] || ((bus.res_kind == KIND_COND) && bus.res_taken);
  assign act_npc   = act_taken ? bus.res_target : bus.res_pc + AW'(4);

  assign bus.pcclear     = bus.res_valid && (act_npc != bus.res_pred_npc);
  assign bus.redirect_pc = act_npc;
  assign upd             = bus.res_valid && bus.pcen;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC[AW-1:0];
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (bus.pcen) begin
      pc_q <= bus.pcclear ? bus.redirect_pc : bus.pred_npc;
      if (bus.res_valid) begin
        case (bus.res_kind)
          KIND_COND: begin
            if (res_hit) begin
              if (bus.res_taken) begin
                target_q[res_idx] <= bus.res_target;
                if (res_ctr != CTR_ST) ctr_q[res_idx] <= res_ctr + 2'd1;
              end else if (res_ctr != CTR_SNT) begin
                ctr_q[res_idx] <= res_ctr - 2'd1;
              end
            end else begin
              valid_q[res_idx]  <= 1'b1;
              tag_q[res_idx]    <= bus.res_pc[AW-1:IW+2];
              target_q[res_idx] <= bus.res_target;
              ctr_q[res_idx]    <= bus.res_taken ? CTR_WT : CTR_WNT;
            end
          end
          KIND_JUMP, KIND_JR: begin
            valid_q[res_idx]  <= 1'b1;
            tag_q[res_idx]    <= bus.res_pc[AW-1:IW+2];
            target_q[res_idx] <= bus.res_target;
            ctr_q[res_idx]    <= CTR_ST;
          end
          default: begin
            // A non-branch that hits means the entry aliased; drop it.
            if (res_hit) valid_q[res_idx] <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CW)) u_uncond (
    .clk(clk), .rst_n(rst_n), .clr(bus.stat_clr),
    .inc(upd && bus.res_kind[1]), .q(bus.uncondsum)
  );

  sat_counter #(.W(CW)) u_cond (
    .clk(clk), .rst_n(rst_n), .clr(bus.stat_clr),
    .inc(upd && (bus.res_kind == KIND_COND)), .q(bus.condsum)
  );

  sat_counter #(.W(CW)) u_condsucc (
    .clk(clk), .rst_n(rst_n), .clr(bus.stat_clr),
    .inc(upd && (bus.res_kind == KIND_COND) && bus.res_taken), .q(bus.condsuccsum)
  );

  sat_counter #(.W(CW)) u_mispred (
    .clk(clk), .rst_n(rst_n), .clr(bus.stat_clr),
    .inc(upd && bus.pcclear), .q(bus.mispredsum)
  );

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: prediction, redirect, BTB update/aliasing, stall,
// statistics clear/saturation and reset during a redirect.
module tb_npc_bpred;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  npc_bpred_if #(.AW(32), .CW(16)) bus ();
  npc_bpred_if #(.AW(32), .CW(2))  bus2 ();

  npc_bpred #(.AW(32), .ENTRIES(16), .CW(16), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  npc_bpred #(.AW(32), .ENTRIES(4), .CW(2), .RESET_PC(32'h0000_3000)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_unc = 0, exp_cond = 0, exp_succ = 0, exp_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [1:0] kind, input logic [31:0] rpc, input logic taken,
                         input logic [31:0] target, input logic [31:0] pred);
    bus.res_valid    = 1'b1;
    bus.res_kind     = kind;
    bus.res_pc       = rpc;
    bus.res_taken    = taken;
    bus.res_target   = target;
    bus.res_pred_npc = pred;
    #1;
  endtask

  task automatic idle();
    bus.res_valid = 1'b0;
    #1;
  endtask

  // Steer fetch to addr via a non-branch at addr-4 whose prediction was wrong.
  task automatic redirect_to(input logic [31:0] addr);
    resolve(KIND_NONE, addr - 32'd4, 1'b0, 32'd0, 32'd0);
    tick();
    idle();
    exp_mis++;
    check("redir_pc", bus.pc, addr);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_unc"},  32'(bus.uncondsum),   32'(exp_unc));
    check({tag, "_cond"}, 32'(bus.condsum),     32'(exp_cond));
    check({tag, "_succ"}, 32'(bus.condsuccsum), 32'(exp_succ));
    check({tag, "_mis"},  32'(bus.mispredsum),  32'(exp_mis));
  endtask

  initial begin
    bus.pcen = 1'b1;  bus.stat_clr = 1'b0;  bus.res_valid = 1'b0;
    bus.res_kind = 2'd0;  bus.res_pc = '0;  bus.res_taken = 1'b0;
    bus.res_target = '0;  bus.res_pred_npc = '0;
    bus2.pcen = 1'b1; bus2.stat_clr = 1'b0; bus2.res_valid = 1'b0;
    bus2.res_kind = 2'd0; bus2.res_pc = '0; bus2.res_taken = 1'b0;
    bus2.res_target = '0; bus2.res_pred_npc = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Sequential fetch out of reset
    check("rst_pc", bus.pc, 32'h3000);
    check("rst_pt", 32'(bus.pred_taken), 32'd0);
    check("rst_npc", bus.pred_npc, 32'h3004);
    check_stats("rst");
    tick();
    check("seq_pc1", bus.pc, 32'h3004);
    tick();
    check("seq_pc2", bus.pc, 32'h3008);

    // Cond branch taken, predicted fall-through
    resolve(KIND_COND, 32'h3010, 1'b1, 32'h3040, 32'h3014);
    check("a_clr", 32'(bus.pcclear), 32'd1);
    check("a_redir", bus.redirect_pc, 32'h3040);
    tick();
    idle();
    check("a_pc", bus.pc, 32'h3040);
    exp_cond++; exp_succ++; exp_mis++;
    check_stats("a");

    redirect_to(32'h3010);
    check("a_pt", 32'(bus.pred_taken), 32'd1);
    check("a_pnpc", bus.pred_npc, 32'h3040);

    // Train up to saturation, then one not-taken step back to weakly taken
    resolve(KIND_COND, 32'h3010, 1'b1, 32'h3040, 32'h3040);
    check("b_clr", 32'(bus.pcclear), 32'd0);
    tick();
    exp_cond++; exp_succ++;
    resolve(KIND_COND, 32'h3010, 1'b1, 32'h3040, 32'h3040);
    tick();
    exp_cond++; exp_succ++;
    resolve(KIND_COND, 32'h3010, 1'b0, 32'h3040, 32'h3014);
    check("d_clr", 32'(bus.pcclear), 32'd0);
    tick();
    idle();
    exp_cond++;
    redirect_to(32'h3010);
    check("d_pt", 32'(bus.pred_taken), 32'd1);

    resolve(KIND_COND, 32'h3010, 1'b0, 32'h3040, 32'h3040);
    check("e_clr", 32'(bus.pcclear), 32'd1);
    check("e_redir", bus.redirect_pc, 32'h3014);
    tick();
    idle();
    exp_cond++; exp_mis++;
    redirect_to(32'h3010);
    check("e_pt", 32'(bus.pred_taken), 32'd0);
    check("e_pnpc", bus.pred_npc, 32'h3014);
    check_stats("e");

    // Register jump, then non-branches at an aliasing PC and at the jump itself
    resolve(KIND_JR, 32'h3020, 1'b0, 32'h3100, 32'h3024);
    check("f_redir", bus.redirect_pc, 32'h3100);
    tick();
    check("f_pc", bus.pc, 32'h3100);
    exp_unc++; exp_mis++;
    resolve(KIND_NONE, 32'h3060, 1'b0, 32'h0, 32'h3100);
    check("g_clr", 32'(bus.pcclear), 32'd1);
    check("g_redir", bus.redirect_pc, 32'h3064);
    tick();
    idle();
    exp_mis++;
    redirect_to(32'h3020);
    check("g_pt", 32'(bus.pred_taken), 32'd1);
    check("g_pnpc", bus.pred_npc, 32'h3100);
    resolve(KIND_NONE, 32'h3020, 1'b0, 32'h0, 32'h3100);
    check("h_redir", bus.redirect_pc, 32'h3024);
    tick();
    idle();
    exp_mis++;
    redirect_to(32'h3020);
    check("h_pt", 32'(bus.pred_taken), 32'd0);
    check("h_pnpc", bus.pred_npc, 32'h3024);
    check_stats("h");

    // Stall: nothing may change
    bus.pcen = 1'b0;
    resolve(KIND_JUMP, 32'h3010, 1'b0, 32'h3200, 32'h0);
    tick();
    check("i_pc", bus.pc, 32'h3020);
    check_stats("i");
    bus.pcen = 1'b1;
    idle();
    redirect_to(32'h3010);
    check("i_pt", 32'(bus.pred_taken), 32'd0);

    // Clear beats a same-cycle increment
    bus.stat_clr = 1'b1;
    resolve(KIND_COND, 32'h3080, 1'b1, 32'h3300, 32'h3084);
    tick();
    bus.stat_clr = 1'b0;
    idle();
    exp_unc = 0; exp_cond = 0; exp_succ = 0; exp_mis = 0;
    check_stats("j");
    resolve(KIND_COND, 32'h3080, 1'b1, 32'h3300, 32'h3300);
    check("l_clr", 32'(bus.pcclear), 32'd0);
    tick();
    idle();
    exp_cond++; exp_succ++;
    check_stats("l");

    // Reset wins over a same-cycle redirect
    resolve(KIND_JUMP, 32'h3040, 1'b0, 32'h3400, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    check("k_pc", bus.pc, 32'h3000);
    check("k_pt", 32'(bus.pred_taken), 32'd0);
    exp_unc = 0; exp_cond = 0; exp_succ = 0; exp_mis = 0;
    check_stats("k");
    redirect_to(32'h3080);
    check("k_btb", 32'(bus.pred_taken), 32'd0);

    // Narrow counter saturates instead of wrapping
    bus2.res_valid = 1'b1; bus2.res_kind = KIND_JUMP;
    bus2.res_pc = 32'h3000; bus2.res_target = 32'h3000; bus2.res_pred_npc = 32'h3000;
    for (int i = 0; i < 3; i++) tick();
    check("sat_3", 32'(bus2.uncondsum), 32'd3);
    tick();
    bus2.res_valid = 1'b0;
    #1;
    check("sat_4", 32'(bus2.uncondsum), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
